// File: rtl/datapath_run_ctrl.sv
// Run controller for the single-cycle datapath: free-run, single-step and PC
// breakpoint modes, datapath clock-enable generation and a retired-cycle counter.
module datapath_run_ctrl #(
  parameter int PC_W       = 64,
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mode_run,
  input  logic             step_btn,
  input  logic             halt_req,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_en,
  output logic             halted,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int DEB_W = $clog2(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_t;

  state_t state_reg, state_next;

  logic             btn_meta_reg, btn_sync_reg, btn_stable_reg;
  logic [DEB_W-1:0] deb_cnt_reg;
  logic             step_pulse_reg;
  logic             deb_rise;
  logic             bp_arm_reg, bp_arm_next;
  logic             bp_hit;
  logic             halted_reg;
  logic [CNT_W-1:0] cycle_cnt_reg;

  // Stable level flips after DEB_CYCLES consecutive differing samples.
  assign deb_rise = btn_sync_reg && !btn_stable_reg && (deb_cnt_reg == DEB_MAX);

  always_ff @(posedge clock) begin
    if (!reset) begin
      btn_meta_reg   <= 1'b0;
      btn_sync_reg   <= 1'b0;
      btn_stable_reg <= 1'b0;
      deb_cnt_reg    <= '0;
      step_pulse_reg <= 1'b0;
    end else begin
      btn_meta_reg   <= step_btn;
      btn_sync_reg   <= btn_meta_reg;
      step_pulse_reg <= deb_rise;
      if (btn_sync_reg == btn_stable_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DEB_MAX) begin
        btn_stable_reg <= btn_sync_reg;
        deb_cnt_reg    <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
      end
    end
  end

  assign bp_hit = bp_en && bp_arm_reg && (pc == bp_addr);

  always_comb begin
    state_next  = state_reg;
    bp_arm_next = 1'b1;
    cpu_en      = !halt_req &&
                  (((state_reg == ST_RUN) && !bp_hit) || (state_reg == ST_STEP));
    case (state_reg)
      ST_HALT: begin
        if (halt_req)            state_next = ST_HALT;
        else if (mode_run)       state_next = ST_RUN;
        else if (step_pulse_reg) state_next = ST_STEP;
      end
      ST_RUN: begin
        if (halt_req || !mode_run) state_next = ST_HALT;
        else if (bp_hit)           state_next = ST_BREAK;
      end
      ST_STEP: state_next = ST_HALT;
      ST_BREAK: begin
        if (halt_req) begin
          state_next = ST_HALT;
        end else if (step_pulse_reg) begin
          // Disarm for the resume cycle so the breakpoint instruction executes once.
          if (mode_run) begin
            state_next  = ST_RUN;
            bp_arm_next = 1'b0;
          end else begin
            state_next = ST_STEP;
          end
        end
      end
      default: state_next = ST_HALT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= ST_HALT;
      bp_arm_reg    <= 1'b1;
      halted_reg    <= 1'b1;
      cycle_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      bp_arm_reg <= bp_arm_next;
      halted_reg <= (state_next == ST_HALT) || (state_next == ST_BREAK);
      if (cpu_en && !(&cycle_cnt_reg)) begin
        cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign state_o   = state_reg;
  assign halted    = halted_reg;
  assign cycle_cnt = cycle_cnt_reg;

endmodule

// File: tb/tb_datapath_run_ctrl.sv
// Scoreboard bench for datapath_run_ctrl: per-cycle stimulus vectors push the
// expected enable/state/counter values, which are popped and compared each clock.
module tb_datapath_run_ctrl;

  localparam logic [1:0] HALT = 2'b00, RUN = 2'b01, STEP = 2'b10, BRK = 2'b11;

  logic        clock, reset, mode_run, step_btn, halt_req, bp_en;
  logic [63:0] bp_addr, pc;
  logic        cpu_en, halted, cpu_en4, halted4;
  logic [1:0]  state_o, state4;
  logic [31:0] cycle_cnt;
  logic [3:0]  cycle_cnt4;

  datapath_run_ctrl dut (
    .clock(clock), .reset(reset), .mode_run(mode_run), .step_btn(step_btn),
    .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_en(cpu_en), .halted(halted), .state_o(state_o), .cycle_cnt(cycle_cnt)
  );

  datapath_run_ctrl #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .mode_run(mode_run), .step_btn(step_btn),
    .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_en(cpu_en4), .halted(halted4), .state_o(state4), .cycle_cnt(cycle_cnt4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic rst_n, run, btn, hreq, bpe;
    logic [7:0] pcv;
    logic en;
    logic [1:0] st;
  } vec_t;

  typedef struct {
    logic en;
    logic [1:0] st;
    logic hl;
    logic [31:0] cnt;
    logic [3:0] cnt4;
  } exp_t;

  vec_t stim_q[$];
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] mcnt = '0;
  logic [3:0]  mcnt4 = '0;

  task automatic add(input logic rst_n, input logic run, input logic btn, input logic hreq,
                     input logic bpe, input logic [7:0] pcv, input logic en,
                     input logic [1:0] st, input int n);
    vec_t v;
    v.rst_n = rst_n; v.run = run; v.btn = btn; v.hreq = hreq; v.bpe = bpe;
    v.pcv = pcv; v.en = en; v.st = st;
    for (int i = 0; i < n; i++) stim_q.push_back(v);
  endtask

  // Drive one cycle of inputs and queue what the design must show for it.
  task automatic drive(input vec_t v);
    exp_t e;
    reset = v.rst_n; mode_run = v.run; step_btn = v.btn; halt_req = v.hreq;
    bp_en = v.bpe; pc = {56'd0, v.pcv};
    if (!v.rst_n) begin
      mcnt = '0; mcnt4 = '0;
    end else if (v.en) begin
      if (mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
      if (mcnt4 != 4'hF) mcnt4 = mcnt4 + 4'd1;
    end
    e.en = v.en; e.st = v.st; e.hl = (v.st == HALT) || (v.st == BRK);
    e.cnt = mcnt; e.cnt4 = mcnt4;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    vec_t v; exp_t e; int cyc = 0;
    add(0, 1, 0, 0, 0, 8'h00, 0, HALT, 3);
    while (stim_q.size() > 0) begin
      v = stim_q.pop_front(); drive(v); #1; e = exp_q.pop_front();
      checks++; if (cpu_en !== e.en) begin errors++; $display("FAIL reset cyc%0d cpu_en got %b want %b", cyc, cpu_en, e.en); end
      @(posedge clock); #1;
      checks++; if (state_o !== e.st) begin errors++; $display("FAIL reset cyc%0d state got %b want %b", cyc, state_o, e.st); end
      checks++; if (halted !== e.hl) begin errors++; $display("FAIL reset cyc%0d halted got %b want %b", cyc, halted, e.hl); end
      checks++; if (cycle_cnt !== e.cnt) begin errors++; $display("FAIL reset cyc%0d cnt got %0d want %0d", cyc, cycle_cnt, e.cnt); end
      checks++; if (cycle_cnt4 !== e.cnt4) begin errors++; $display("FAIL reset cyc%0d cnt4 got %0d want %0d", cyc, cycle_cnt4, e.cnt4); end
      cyc++;
    end
  endtask

  task automatic test_run;
    vec_t v; exp_t e; int cyc = 0;
    add(1, 1, 0, 0, 0, 8'h00, 0, RUN, 1);
    add(1, 1, 0, 0, 0, 8'h00, 1, RUN, 20);
    while (stim_q.size() > 0) begin
      v = stim_q.pop_front(); drive(v); #1; e = exp_q.pop_front();
      checks++; if (cpu_en !== e.en) begin errors++; $display("FAIL run cyc%0d cpu_en got %b want %b", cyc, cpu_en, e.en); end
      checks++; if (cpu_en4 !== e.en) begin errors++; $display("FAIL run cyc%0d cpu_en4 got %b want %b", cyc, cpu_en4, e.en); end
      @(posedge clock); #1;
      checks++; if (state_o !== e.st) begin errors++; $display("FAIL run cyc%0d state got %b want %b", cyc, state_o, e.st); end
      checks++; if (state4 !== e.st) begin errors++; $display("FAIL run cyc%0d state4 got %b want %b", cyc, state4, e.st); end
      checks++; if (halted !== e.hl) begin errors++; $display("FAIL run cyc%0d halted got %b want %b", cyc, halted, e.hl); end
      checks++; if (halted4 !== e.hl) begin errors++; $display("FAIL run cyc%0d halted4 got %b want %b", cyc, halted4, e.hl); end
      checks++; if (cycle_cnt !== e.cnt) begin errors++; $display("FAIL run cyc%0d cnt got %0d want %0d", cyc, cycle_cnt, e.cnt); end
      checks++; if (cycle_cnt4 !== e.cnt4) begin errors++; $display("FAIL run cyc%0d cnt4_sat got %0d want %0d", cyc, cycle_cnt4, e.cnt4); end
      cyc++;
    end
  endtask

  task automatic test_halt_req;
    vec_t v; exp_t e; int cyc = 0;
    add(1, 1, 0, 1, 0, 8'h00, 0, HALT, 1);
    add(1, 1, 0, 0, 0, 8'h00, 0, RUN,  1);
    add(1, 1, 0, 1, 1, 8'h40, 0, HALT, 1);
    add(1, 0, 0, 0, 0, 8'h40, 0, HALT, 1);
    while (stim_q.size() > 0) begin
      v = stim_q.pop_front(); drive(v); #1; e = exp_q.pop_front();
      checks++; if (cpu_en !== e.en) begin errors++; $display("FAIL halt_req cyc%0d cpu_en got %b want %b", cyc, cpu_en, e.en); end
      @(posedge clock); #1;
      checks++; if (state_o !== e.st) begin errors++; $display("FAIL halt_req cyc%0d state got %b want %b", cyc, state_o, e.st); end
      checks++; if (halted !== e.hl) begin errors++; $display("FAIL halt_req cyc%0d halted got %b want %b", cyc, halted, e.hl); end
      checks++; if (cycle_cnt !== e.cnt) begin errors++; $display("FAIL halt_req cyc%0d cnt got %0d want %0d", cyc, cycle_cnt, e.cnt); end
      cyc++;
    end
  endtask

  task automatic test_breakpoint;
    vec_t v; exp_t e; int cyc = 0;
    add(1, 1, 0, 0, 1, 8'h38, 0, RUN, 1);
    add(1, 1, 0, 0, 1, 8'h38, 1, RUN, 1);
    add(1, 1, 0, 0, 1, 8'h3C, 1, RUN, 1);
    add(1, 1, 0, 0, 1, 8'h40, 0, BRK, 1);
    add(1, 0, 0, 0, 1, 8'h40, 0, BRK, 1);
    add(1, 1, 0, 0, 1, 8'h40, 0, BRK, 1);
    add(1, 1, 1, 0, 1, 8'h40, 0, BRK, 18);
    add(1, 1, 1, 0, 1, 8'h40, 0, RUN, 1);
    add(1, 1, 1, 0, 1, 8'h40, 1, RUN, 1);
    add(1, 1, 1, 0, 1, 8'h44, 1, RUN, 1);
    add(1, 1, 1, 0, 1, 8'h40, 0, BRK, 1);
    add(1, 0, 0, 0, 0, 8'h40, 0, BRK, 1);
    add(1, 0, 0, 1, 0, 8'h40, 0, HALT, 1);
    while (stim_q.size() > 0) begin
      v = stim_q.pop_front(); drive(v); #1; e = exp_q.pop_front();
      checks++; if (cpu_en !== e.en) begin errors++; $display("FAIL bp cyc%0d cpu_en got %b want %b", cyc, cpu_en, e.en); end
      @(posedge clock); #1;
      checks++; if (state_o !== e.st) begin errors++; $display("FAIL bp cyc%0d state got %b want %b", cyc, state_o, e.st); end
      checks++; if (halted !== e.hl) begin errors++; $display("FAIL bp cyc%0d halted got %b want %b", cyc, halted, e.hl); end
      checks++; if (cycle_cnt !== e.cnt) begin errors++; $display("FAIL bp cyc%0d cnt got %0d want %0d", cyc, cycle_cnt, e.cnt); end
      cyc++;
    end
  endtask

  task automatic test_step;
    vec_t v; exp_t e; int cyc = 0;
    add(1, 0, 0, 0, 0, 8'h00, 0, HALT, 20);
    add(1, 0, 1, 0, 0, 8'h00, 0, HALT, 18);
    add(1, 0, 1, 0, 0, 8'h00, 0, STEP, 1);
    add(1, 0, 1, 0, 0, 8'h00, 1, HALT, 1);
    add(1, 0, 1, 0, 0, 8'h00, 0, HALT, 20);
    add(1, 0, 0, 0, 0, 8'h00, 0, HALT, 20);
    add(1, 0, 1, 0, 0, 8'h00, 0, HALT, 5);
    add(1, 0, 0, 0, 0, 8'h00, 0, HALT, 25);
    while (stim_q.size() > 0) begin
      v = stim_q.pop_front(); drive(v); #1; e = exp_q.pop_front();
      checks++; if (cpu_en !== e.en) begin errors++; $display("FAIL step cyc%0d cpu_en got %b want %b", cyc, cpu_en, e.en); end
      @(posedge clock); #1;
      checks++; if (state_o !== e.st) begin errors++; $display("FAIL step cyc%0d state got %b want %b", cyc, state_o, e.st); end
      checks++; if (halted !== e.hl) begin errors++; $display("FAIL step cyc%0d halted got %b want %b", cyc, halted, e.hl); end
      checks++; if (cycle_cnt !== e.cnt) begin errors++; $display("FAIL step cyc%0d cnt got %0d want %0d", cyc, cycle_cnt, e.cnt); end
      cyc++;
    end
  endtask

  task automatic test_reset_mid;
    vec_t v; exp_t e; int cyc = 0;
    add(1, 0, 1, 0, 0, 8'h00, 0, HALT, 18);
    add(1, 0, 1, 0, 0, 8'h00, 0, STEP, 1);
    add(0, 0, 0, 0, 0, 8'h00, 1, HALT, 1);
    add(1, 0, 0, 0, 0, 8'h00, 0, HALT, 1);
    add(1, 1, 0, 0, 1, 8'h40, 0, RUN, 1);
    add(1, 1, 0, 0, 1, 8'h40, 0, BRK, 1);
    add(1, 0, 1, 0, 1, 8'h40, 0, BRK, 10);
    add(0, 0, 1, 0, 1, 8'h40, 0, HALT, 1);
    add(1, 0, 1, 0, 0, 8'h40, 0, HALT, 18);
    add(1, 0, 1, 0, 0, 8'h40, 0, STEP, 1);
    add(1, 0, 1, 0, 0, 8'h40, 1, HALT, 1);
    add(1, 0, 0, 0, 0, 8'h40, 0, HALT, 3);
    while (stim_q.size() > 0) begin
      v = stim_q.pop_front(); drive(v); #1; e = exp_q.pop_front();
      checks++; if (cpu_en !== e.en) begin errors++; $display("FAIL reset_mid cyc%0d cpu_en got %b want %b", cyc, cpu_en, e.en); end
      @(posedge clock); #1;
      checks++; if (state_o !== e.st) begin errors++; $display("FAIL reset_mid cyc%0d state got %b want %b", cyc, state_o, e.st); end
      checks++; if (halted !== e.hl) begin errors++; $display("FAIL reset_mid cyc%0d halted got %b want %b", cyc, halted, e.hl); end
      checks++; if (cycle_cnt !== e.cnt) begin errors++; $display("FAIL reset_mid cyc%0d cnt got %0d want %0d", cyc, cycle_cnt, e.cnt); end
      cyc++;
    end
  endtask

  initial begin
    reset = 1'b0; mode_run = 1'b0; step_btn = 1'b0; halt_req = 1'b0;
    bp_en = 1'b0; bp_addr = 64'h40; pc = 64'h0;
    @(posedge clock); #1;
    test_reset;
    test_run;
    test_halt_req;
    test_breakpoint;
    test_step;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_run_ctrl.md
Name: datapath_run_ctrl

Overview:
- Execution controller for the single-cycle ARMv8 datapath on the FPGA board.
- Generates the datapath clock-enable and supports three execution modes: free-run, single-step from a debounced push button, and PC breakpoint.
- Keeps a retired-cycle counter for the seven-segment display.
- Sits between the board inputs (switches and button) and the datapath's enable; reads back the datapath's PC.

Parameters:
PC_W, 64, width of PC and breakpoint address (matches the instruction address bus)
DEB_CYCLES, 16, consecutive stable samples required to accept a button level change (>=2)
CNT_W, 32, width of the retired-cycle counter

Ports:
clock  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clock)
mode_run  in  1  switch: 1 = free-run, 0 = single-step
step_btn  in  1  raw asynchronous push button, active-high
halt_req  in  1  level; forces the halt state and suppresses cpu_en
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint address
pc  in  PC_W  current datapath PC (address of the next instruction to execute)
cpu_en  out  1  datapath enable; the datapath advances one instruction on each clock where this is 1
halted  out  1  1 in the HALT or BREAK state
state_o  out  2  HALT=00, RUN=01, STEP=10, BREAK=11
cycle_cnt  out  CNT_W  number of clocks with cpu_en=1

Behaviour:
Reset (reset=0 at a clock edge):
- state=HALT, cycle_cnt=0.
- Synchroniser and debounce registers cleared; stable level=0.
- bp_arm=1.
- Outputs: cpu_en=0, halted=1, state_o=00.
- Reset mid-RUN or mid-STEP takes effect at that edge; no further enable is issued.

Button path:
- 2-flop synchroniser on step_btn.
- Debounce counter resets whenever the synchronised level equals the stable level.
- When the counter reaches DEB_CYCLES-1 with the level still different, the stable level updates.
- step_pulse = 1 for exactly one clock on a 0->1 stable-level change. Release generates no pulse.
- Latency from a clean press to step_pulse: 2 + DEB_CYCLES clocks.

Breakpoint:
- bp_hit = bp_en & bp_arm & (pc == bp_addr), compared over the full PC_W bits.
- bp_arm clears for exactly the first RUN cycle after BREAK->RUN, then sets again. Resuming at the breakpoint PC therefore executes it once rather than re-trapping.

cpu_en (Mealy):
- cpu_en = !halt_req & ((state==RUN & !bp_hit) | state==STEP).
- The instruction at a breakpoint is not executed.

State transitions (halt_req has the highest priority in every state):
- HALT:
  - halt_req -> HALT.
  - mode_run -> RUN.
  - step_pulse -> STEP.
  - otherwise stay.
- RUN:
  - halt_req or !mode_run -> HALT.
  - bp_hit -> BREAK.
  - otherwise stay.
- STEP:
  - Always -> HALT after one clock, so exactly one enable per press.
  - A step_pulse arriving while in STEP is dropped.
- BREAK:
  - halt_req -> HALT.
  - step_pulse & mode_run -> RUN (bp_arm=0 for that first RUN cycle).
  - step_pulse & !mode_run -> STEP.
  - A mode_run change alone does not leave BREAK.

Outputs:
- halted = (state==HALT | state==BREAK). Registered, decoded from state.
- cycle_cnt increments on each clock where cpu_en=1.
- cycle_cnt saturates at all-ones; there is no wrap.
- cycle_cnt is cleared only by reset.

Test Plan:
- Reset then mode_run=1, halt_req=0, bp_en=0 -> state_o=01 one clock after reset releases; cpu_en=1 every clock; cycle_cnt=10 after 10 RUN clocks.
- mode_run=0, step_btn held high 40 clocks (DEB_CYCLES=16) -> one step_pulse at clock 18; STEP for 1 clock (cpu_en=1); back to HALT; cycle_cnt+1. A glitch of 5 clocks gives no step.
- RUN with bp_en=1, bp_addr=0x40, pc stepping 0x38, 0x3C, 0x40 -> cpu_en=0 in the cycle pc=0x40; state_o=11 next; cycle_cnt unchanged. Press button with mode_run=1 -> RUN; 0x40 executes once; no immediate re-trap.
- halt_req=1 during RUN and simultaneously with bp_hit -> cpu_en=0 that same clock; state=HALT (not BREAK); halted=1.
- Preload cycle_cnt near all-ones (CNT_W=4 build): 20 RUN clocks -> cycle_cnt sticks at 0xF.
- reset=0 asserted while in STEP or BREAK -> next clock state_o=00, cpu_en=0, cycle_cnt=0; a button pulse in flight is discarded.
